// File: rtl/apb_trigger_input_filter_pkg.sv
// Shared channel configuration type and per-port register offsets for the trigger input filter.
package CrossbarTypes;

  typedef struct packed {
    logic       invert;
    logic [7:0] filtlen;
  } trigfilt_cfg_t;

  localparam logic [4:0]  REG_CONFIG       = 5'h00;
  localparam logic [4:0]  REG_EDGE_COUNT   = 5'h04;
  localparam logic [4:0]  REG_STATUS       = 5'h08;
  localparam int unsigned PORT_STRIDE_BITS = 5;

endpackage

// File: rtl/apb_trigger_input_filter_apb_if.sv
// APB bus bundle; the completer modport is what a register block sees.
interface apb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic pclk,
  input logic preset_n
);
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport completer (
    input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_trigger_input_filter_chan.sv
// One trigger channel: 2-flop synchronizer, run-length glitch filter, polarity invert,
// and a saturating rising-edge counter when TRIG_EDGE_COUNTER_EN is defined.
module TriggerGlitchFilter
  import CrossbarTypes::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig_in,
  input  trigfilt_cfg_t cfg,
  input  logic          edge_clr,
  output logic          trig_out,
  output logic          sync_level,
  output logic [31:0]   edge_count
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_ff;
  logic [7:0] cnt;
  logic       filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[0], trig_in};
    end
  end

  assign sync_level = sync_ff[1];

  // cnt is never reset by a filtlen change; a count past the new limit wraps before matching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_level != filt) begin
      if (cnt == cfg.filtlen) begin
        filt <= sync_level;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign trig_out = filt ^ cfg.invert;

`ifdef TRIG_EDGE_COUNTER_EN
  logic        trig_out_q;
  logic        rise;
  logic [31:0] edge_cnt;

  assign rise = trig_out && !trig_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_out_q <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      trig_out_q <= trig_out;
      if (edge_clr) begin
        edge_cnt <= {31'h0, rise};
      end else if (rise && edge_cnt != 32'hFFFF_FFFF) begin
        edge_cnt <= edge_cnt + 32'd1;
      end
    end
  end

  assign edge_count = edge_cnt;
`else
  logic unused_edge_clr;
  assign unused_edge_clr = edge_clr;
  assign edge_count      = '0;
`endif

endmodule

// File: rtl/apb_trigger_input_filter.sv
// APB register decode around NUM_PORTS trigger filter channels, zero wait states.
// Per-port EDGE_COUNT counters exist only when TRIG_EDGE_COUNTER_EN is defined.
module apb_trigger_input_filter
  import CrossbarTypes::*;
#(
  parameter int NUM_PORTS = 12
) (
  apb_if.completer             apb,
  input  logic [NUM_PORTS-1:0] trig_in,
  output logic [NUM_PORTS-1:0] trig_out
);

  if ($bits(apb.prdata) != 32) begin : g_bad_width
    $error("apb_trigger_input_filter requires a 32-bit APB data bus");
  end

  logic [31:0]          port_idx;
  logic [4:0]           offset;
  logic                 access;
  logic                 addr_ok;
  logic                 err;
  logic                 wr_en;
  logic                 rd_en;
  trigfilt_cfg_t        cfg [NUM_PORTS];
  logic [NUM_PORTS-1:0] sync_level;
  logic [31:0]          edge_count [NUM_PORTS];
  logic                 unused_pwdata;

  assign port_idx = 32'(apb.paddr >> PORT_STRIDE_BITS);
  assign offset   = apb.paddr[4:0];
  assign access   = apb.psel && apb.penable;
  // Valid offsets all have paddr[1:0] == 0, so misalignment falls out of the offset match.
  assign addr_ok  = (port_idx < 32'(NUM_PORTS)) &&
                    (offset == REG_CONFIG || offset == REG_EDGE_COUNT || offset == REG_STATUS);
  assign err      = !addr_ok || (apb.pwrite && offset == REG_STATUS);
  assign wr_en    = access && apb.pwrite && !err;
  assign rd_en    = access && !apb.pwrite && !err;

  assign apb.pready    = access;
  assign apb.pslverr   = access && err;
  assign unused_pwdata = ^{apb.pwdata[31:16], apb.pwdata[7:1]};

  always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
    if (!apb.preset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) cfg[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en && offset == REG_CONFIG && port_idx == 32'(p)) begin
          cfg[p] <= '{invert: apb.pwdata[0], filtlen: apb.pwdata[15:8]};
        end
      end
    end
  end

  always_comb begin
    apb.prdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_en && port_idx == 32'(p)) begin
        case (offset)
          REG_CONFIG:     apb.prdata = {16'h0, cfg[p].filtlen, 7'h0, cfg[p].invert};
          REG_EDGE_COUNT: apb.prdata = edge_count[p];
          REG_STATUS:     apb.prdata = {30'h0, sync_level[p], trig_out[p]};
          default:        apb.prdata = '0;
        endcase
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    TriggerGlitchFilter u_filt (
      .clk        (apb.pclk),
      .rst_n      (apb.preset_n),
      .trig_in    (trig_in[p]),
      .cfg        (cfg[p]),
      .edge_clr   (wr_en && offset == REG_EDGE_COUNT && port_idx == 32'(p)),
      .trig_out   (trig_out[p]),
      .sync_level (sync_level[p]),
      .edge_count (edge_count[p])
    );
  end

endmodule

// File: tb/tb_apb_trigger_input_filter.sv
// Bench for apb_trigger_input_filter: per-cycle behavioural model plus directed scenarios.
module tb_apb_trigger_input_filter;
  localparam int NP = 12;
`ifdef TRIG_EDGE_COUNTER_EN
  localparam bit HAS_EC = 1'b1;
`else
  localparam bit HAS_EC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] trig_in = '0;
  logic [NP-1:0] trig_out;
  bit            chk_en = 1'b0;
  bit            force_req = 1'b0;
  int            n_cmp = 0;
  int            n_fail = 0;

  apb_if #(.AW(32), .DW(32)) apb (.pclk(clk), .preset_n(rst_n));

  apb_trigger_input_filter #(.NUM_PORTS(NP)) dut (
    .apb      (apb),
    .trig_in  (trig_in),
    .trig_out (trig_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NP-1:0] hist [$];      // trig_in samples from the last two edges, oldest first
  logic [NP-1:0] m_filt, m_inv, m_prev_out, m_out_before, m_syn;
  int unsigned   m_run [NP];    // consecutive synced samples disagreeing with the held level
  logic [7:0]    m_len [NP];
  logic [31:0]   m_ec  [NP];
  logic [31:0]   m_a;
  bit            m_wr_ok, m_rise;
  int            m_wp;

  function automatic bit m_err(input logic [31:0] a, input logic w);
    return (a[1:0] != 2'b0) || ((a >> 5) >= 32'(NP)) ||
           !(a[4:0] inside {5'h00, 5'h04, 5'h08}) || (w && a[4:0] == 5'h08);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int p;
    if (m_err(a, 1'b0)) return 32'h0;
    p = int'(a >> 5);
    case (a[4:0])
      5'h00:   return {16'h0, m_len[p], 7'h0, m_inv[p]};
      5'h04:   return HAS_EC ? m_ec[p] : 32'h0;
      default: return {30'h0, hist[0][p], m_filt[p] ^ m_inv[p]};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_filt = '0; m_inv = '0; m_prev_out = '0;
      for (int p = 0; p < NP; p++) begin
        m_run[p] = 0; m_len[p] = '0; m_ec[p] = '0;
      end
    end else begin
      m_out_before = m_filt ^ m_inv;
      m_syn   = hist[0];
      m_a     = apb.paddr;
      m_wr_ok = apb.psel && apb.penable && apb.pwrite && !m_err(m_a, 1'b1);
      m_wp    = int'(m_a >> 5);
      for (int p = 0; p < NP; p++) begin
        m_rise = m_out_before[p] && !m_prev_out[p];
        if (m_wr_ok && m_wp == p && m_a[4:0] == 5'h04) m_ec[p] = {31'h0, m_rise};
        else if (m_rise && m_ec[p] != 32'hFFFF_FFFF) m_ec[p] = m_ec[p] + 1;
        if (m_syn[p] == m_filt[p]) m_run[p] = 0;
        else if (m_run[p] == 32'(m_len[p])) begin
          m_filt[p] = m_syn[p];
          m_run[p]  = 0;
        end else m_run[p] = (m_run[p] + 1) % 256;
      end
      if (force_req) m_ec[3] = 32'hFFFF_FFFF;
      m_prev_out = m_out_before;
      if (m_wr_ok && m_a[4:0] == 5'h00) begin
        m_len[m_wp] = apb.pwdata[15:8];
        m_inv[m_wp] = apb.pwdata[0];
      end
      hist.push_back(trig_in);
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("trig_out", 32'(trig_out), 32'(m_filt ^ m_inv));
      check("pready", 32'(apb.pready), 32'(apb.psel && apb.penable));
      check("prdata", apb.prdata,
            (apb.psel && apb.penable && !apb.pwrite) ? m_read(apb.paddr) : 32'h0);
      if (apb.psel && apb.penable)
        check("pslverr", 32'(apb.pslverr), 32'(m_err(apb.paddr, apb.pwrite)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
    @(posedge clk); #2;
    apb.penable = 1'b1;
    @(negedge clk);
    rdata = apb.prdata;
    err   = apb.pslverr;
    @(posedge clk); #2;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd; logic er;
    apb_xfer(1'b1, addr, data, rd, er);
    check("write_slverr", 32'(er), 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic er;
    apb_xfer(1'b0, addr, 32'h0, rd, er);
    check(name, rd, exp);
    check({name, "_slverr"}, 32'(er), 32'h0);
  endtask

  task automatic err_chk(input string name, input logic wr, input logic [31:0] addr);
    logic [31:0] rd; logic er;
    apb_xfer(wr, addr, 32'hFFFF_FFFF, rd, er);
    check({name, "_slverr"}, 32'(er), 32'h1);
    check({name, "_prdata"}, rd, 32'h0);
  endtask

  initial begin
    int rise_at;
    bit seen;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    tick(3);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    check("reset_trig_out", 32'(trig_out), 32'h0);
    rd_chk("reset_cfg0", 32'h000, 32'h0);
    rd_chk("reset_status11", 32'h168, 32'h0);

    // Port 0: invert with filtlen 0 right after reset
    wr_ok(32'h000, 32'h0000_0001);
    check("inv_trig_out0", 32'(trig_out[0]), 32'h1);
    rd_chk("inv_edge0", 32'h004, HAS_EC ? 32'h1 : 32'h0);
    trig_in[0] = 1'b1;
    rise_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (!trig_out[0] && rise_at < 0) rise_at = i;
    end
    check("p0_fall_latency", 32'(rise_at), 32'd3);
    rd_chk("p0_status", 32'h008, 32'h2);
    trig_in[0] = 1'b0;
    tick(2);
    check("p0_rise_not_yet", 32'(trig_out[0]), 32'h0);
    tick(1);
    check("p0_rise_at_3", 32'(trig_out[0]), 32'h1);
    rd_chk("p0_edge2", 32'h004, HAS_EC ? 32'h2 : 32'h0);

    // Port 3, filtlen 4: 4-cycle pulse rejected, 6-cycle pulse passes after 7 cycles
    wr_ok(32'h060, 32'h0000_0400);
    trig_in[3] = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      if (trig_out[3]) seen = 1'b1;
      if (i == 4) trig_in[3] = 1'b0;
    end
    check("p3_short_pulse_rejected", 32'(seen), 32'h0);
    trig_in[3] = 1'b1;
    rise_at = -1;
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      if (trig_out[3] && rise_at < 0) rise_at = i;
      if (i == 6) trig_in[3] = 1'b0;
    end
    check("p3_long_pulse_latency", 32'(rise_at), 32'd7);
    rd_chk("p3_edge1", 32'h064, HAS_EC ? 32'h1 : 32'h0);

    // Shrinking filtlen below a running count: count wraps through 255 before the flip
    wr_ok(32'h060, 32'h0000_1400);
    trig_in[3] = 1'b1;
    tick(12);
    wr_ok(32'h060, 32'h0000_0200);
    tick(20);
    check("p3_wrap_no_early_flip", 32'(trig_out[3]), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick(1);
      if (trig_out[3]) seen = 1'b1;
    end
    check("p3_wrap_flip_eventually", 32'(seen), 32'h1);
    trig_in[3] = 1'b0;
    wr_ok(32'h060, 32'h0000_0000);
    tick(6);

    // Saturation and clear coincident with an edge on port 3
`ifdef TRIG_EDGE_COUNTER_EN
    force dut.g_port[3].u_filt.edge_cnt = 32'hFFFF_FFFF;
    force_req = 1'b1;
    tick(1);
    release dut.g_port[3].u_filt.edge_cnt;
    force_req = 1'b0;
`endif
    repeat (3) begin
      trig_in[3] = 1'b1; tick(4);
      trig_in[3] = 1'b0; tick(4);
    end
    rd_chk("p3_edge_saturated", 32'h064, HAS_EC ? 32'hFFFF_FFFF : 32'h0);
    trig_in[3] = 1'b1;
    tick(2);
    wr_ok(32'h064, 32'h0);
    rd_chk("p3_clear_with_edge", 32'h064, HAS_EC ? 32'h1 : 32'h0);
    wr_ok(32'h064, 32'h0);
    rd_chk("p3_clear_no_edge", 32'h064, 32'h0);
    trig_in[3] = 1'b0;
    tick(4);

    // Error responses leave state untouched
    err_chk("rd_port12", 1'b0, 32'h180);
    err_chk("rd_off0c", 1'b0, 32'h00C);
    err_chk("rd_misalign", 1'b0, 32'h002);
    err_chk("wr_status", 1'b1, 32'h008);
    err_chk("wr_misalign", 1'b1, 32'h002);
    err_chk("wr_port12", 1'b1, 32'h180);
    rd_chk("cfg0_unchanged", 32'h000, 32'h0000_0001);

    // Reset in the middle of a long filter count on port 5
    wr_ok(32'h0A0, 32'h0000_C800);
    trig_in[5] = 1'b1;
    tick(100);
    check("p5_mid_count_low", 32'(trig_out[5]), 32'h0);
    rst_n = 1'b0;
    tick(2);
    check("reset_mid_pulse_out", 32'(trig_out), 32'h0);
    rst_n = 1'b1;
    rise_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (trig_out[5] && rise_at < 0) rise_at = i;
    end
    check("p5_post_reset_latency", 32'(rise_at), 32'd3);
    rd_chk("p5_cfg_after_reset", 32'h0A0, 32'h0);
    rd_chk("p5_edge_after_reset", 32'h0A4, HAS_EC ? 32'h1 : 32'h0);
    rd_chk("p0_cfg_after_reset", 32'h000, 32'h0);

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
